// File: rtl/muu_rdcmd_arbiter.sv
// Two-requester read-command arbiter in front of a single memory read port.
// Commands are granted round-robin, with atomic groups (cmd_last=0 ... cmd_last=1)
// locking the grant to one requester. Every accepted command pushes its requester
// index into a tag FIFO. In-order read responses are steered back by the head tag.
module muu_rdcmd_arbiter #(
    parameter int unsigned MEMADDR_WIDTH = 21,
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned TAG_DEPTH     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   req0_cmd_data,
    input  logic                          req0_cmd_last,
    input  logic                          req0_cmd_valid,
    output logic                          req0_cmd_ready,
    input  logic [31:0]                   req1_cmd_data,
    input  logic                          req1_cmd_last,
    input  logic                          req1_cmd_valid,
    output logic                          req1_cmd_ready,
    output logic [31:0]                   mem_rdcmd_data,
    output logic                          mem_rdcmd_valid,
    input  logic                          mem_rdcmd_ready,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data,
    input  logic                          mem_rd_valid,
    output logic                          mem_rd_ready,
    output logic [DATA_WIDTH-1:0]         rsp0_data,
    output logic                          rsp0_valid,
    input  logic                          rsp0_ready,
    output logic [DATA_WIDTH-1:0]         rsp1_data,
    output logic                          rsp1_valid,
    input  logic                          rsp1_ready,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err_unsolicited
);

    localparam int unsigned TagW = $clog2(TAG_DEPTH);
    localparam int unsigned CntW = TagW + 1;
    // Address bits above MEMADDR_WIDTH are cleared on the way to memory.
    localparam logic [31:0] AddrMask = (MEMADDR_WIDTH >= 32) ? 32'hFFFF_FFFF :
                                       ((32'd1 << MEMADDR_WIDTH) - 32'd1);

    typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;       // 0 favours req0 when both are valid
    logic              grant_valid;
    logic              grant_idx;
    logic              sel_valid, sel_last;
    logic [31:0]       sel_data;
    logic              can_issue;
    logic              accept;

    logic              cmd_valid_q;
    logic [31:0]       cmd_data_q;

    logic              tag_mem_q [TAG_DEPTH];
    logic [TagW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              fifo_full, fifo_empty;
    logic              head_tag;
    logic              push, pop;
    logic              err_q;

    // Grant selection: locked states pin the grant, idle arbitrates round-robin.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        case (state_q)
            StIdle: begin
                if (req0_cmd_valid && req1_cmd_valid) begin
                    grant_valid = 1'b1;
                    grant_idx   = prio_q;
                end else if (req0_cmd_valid) begin
                    grant_valid = 1'b1;
                    grant_idx   = 1'b0;
                end else if (req1_cmd_valid) begin
                    grant_valid = 1'b1;
                    grant_idx   = 1'b1;
                end
            end
            StLock0: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end
            StLock1: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
            default: ;
        endcase
    end

    assign sel_valid = grant_idx ? req1_cmd_valid : req0_cmd_valid;
    assign sel_last  = grant_idx ? req1_cmd_last  : req0_cmd_last;
    assign sel_data  = grant_idx ? req1_cmd_data  : req0_cmd_data;

    // Full check uses the registered count only: a pop this cycle does not free a slot.
    assign fifo_full  = (count_q == CntW'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign can_issue  = !fifo_full && (!cmd_valid_q || mem_rdcmd_ready) && !rst;

    assign req0_cmd_ready = grant_valid && !grant_idx && can_issue;
    assign req1_cmd_ready = grant_valid &&  grant_idx && can_issue;
    assign accept         = grant_valid && can_issue && sel_valid;

    // Next-state: a non-final command locks, a final one returns to idle and rotates priority.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (accept) begin
            if (sel_last) begin
                state_d = StIdle;
                prio_d  = ~grant_idx;
            end else begin
                state_d = grant_idx ? StLock1 : StLock0;
            end
        end
    end

    // Arbiter state and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Output command register: load on accept, hold until memory takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
        end else if (accept) begin
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= sel_data & AddrMask;
        end else if (mem_rdcmd_ready) begin
            cmd_valid_q <= 1'b0;
        end
    end

    assign mem_rdcmd_valid = cmd_valid_q;
    assign mem_rdcmd_data  = cmd_data_q;

    assign push     = accept;
    assign pop      = mem_rd_valid && mem_rd_ready;
    assign head_tag = tag_mem_q[rd_ptr_q];

    // Tag storage; contents are meaningless while the count says empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant_idx;
        end
    end

    // Occupancy follows push/pop; simultaneous push and pop cancel.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    // Tag FIFO pointers, occupancy and the sticky unsolicited-response flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (mem_rd_valid && fifo_empty) err_q <= 1'b1;
        end
    end

    // Response steering by head tag; nothing is routed while no tag is pending.
    assign rsp0_valid   = mem_rd_valid && !fifo_empty && !head_tag;
    assign rsp1_valid   = mem_rd_valid && !fifo_empty &&  head_tag;
    assign rsp0_data    = mem_rd_data;
    assign rsp1_data    = mem_rd_data;
    assign mem_rd_ready = !fifo_empty && (head_tag ? rsp1_ready : rsp0_ready);

    assign outstanding     = count_q;
    assign err_unsolicited = err_q;

endmodule

// File: tb/tb_muu_rdcmd_arbiter.sv
// Directed bench for muu_rdcmd_arbiter with hand-computed expectations.
module tb_muu_rdcmd_arbiter;

    localparam int unsigned DW = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   req0_cmd_data, req1_cmd_data;
    logic          req0_cmd_last, req1_cmd_last;
    logic          req0_cmd_valid, req1_cmd_valid;
    logic          req0_cmd_ready, req1_cmd_ready;
    logic [31:0]   mem_rdcmd_data;
    logic          mem_rdcmd_valid, mem_rdcmd_ready;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_valid, mem_rd_ready;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [5:0]    outstanding;
    logic          err_unsolicited;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muu_rdcmd_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req0_cmd_data   (req0_cmd_data),
        .req0_cmd_last   (req0_cmd_last),
        .req0_cmd_valid  (req0_cmd_valid),
        .req0_cmd_ready  (req0_cmd_ready),
        .req1_cmd_data   (req1_cmd_data),
        .req1_cmd_last   (req1_cmd_last),
        .req1_cmd_valid  (req1_cmd_valid),
        .req1_cmd_ready  (req1_cmd_ready),
        .mem_rdcmd_data  (mem_rdcmd_data),
        .mem_rdcmd_valid (mem_rdcmd_valid),
        .mem_rdcmd_ready (mem_rdcmd_ready),
        .mem_rd_data     (mem_rd_data),
        .mem_rd_valid    (mem_rd_valid),
        .mem_rd_ready    (mem_rd_ready),
        .rsp0_data       (rsp0_data),
        .rsp0_valid      (rsp0_valid),
        .rsp0_ready      (rsp0_ready),
        .rsp1_data       (rsp1_data),
        .rsp1_valid      (rsp1_valid),
        .rsp1_ready      (rsp1_ready),
        .outstanding     (outstanding),
        .err_unsolicited (err_unsolicited)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] last_data;

        rst = 1'b1;
        req0_cmd_data = 32'h0; req0_cmd_last = 1'b1; req0_cmd_valid = 1'b1;
        req1_cmd_data = 32'h0; req1_cmd_last = 1'b1; req1_cmd_valid = 1'b0;
        mem_rdcmd_ready = 1'b1;
        mem_rd_data = '0; mem_rd_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset state, with req0 presenting a command
        tick();
        tick();
        check("rst_cmd_valid", 64'(mem_rdcmd_valid), 64'd0);
        check("rst_cmd_data", 64'(mem_rdcmd_data), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_err", 64'(err_unsolicited), 64'd0);
        check("rst_req0_ready", 64'(req0_cmd_ready), 64'd0);

        // Round-robin with both valid and single-command groups
        rst = 1'b0;
        req0_cmd_data = 32'h10; req1_cmd_data = 32'h20;
        req1_cmd_valid = 1'b1;
        #1;
        check("rr_first_r0", 64'(req0_cmd_ready), 64'd1);
        check("rr_first_r1", 64'(req1_cmd_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr_data%0d", i), 64'(mem_rdcmd_data), (i % 2 == 0) ? 64'h10 : 64'h20);
            check($sformatf("rr_out%0d", i), 64'(outstanding), 64'(i + 1));
        end
        req0_cmd_valid = 1'b0; req1_cmd_valid = 1'b0;

        // Drain four responses: tags 0,1,0,1
        mem_rd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rd_data = DW'(64'hA000 + i);
            #1;
            check($sformatf("dr_rsp1v%0d", i), 64'(rsp1_valid), 64'(i % 2));
            check($sformatf("dr_rsp0v%0d", i), 64'(rsp0_valid), 64'(1 - (i % 2)));
            check($sformatf("dr_rdy%0d", i), 64'(mem_rd_ready), 64'd1);
            tick();
            check($sformatf("dr_out%0d", i), 64'(outstanding), 64'(3 - i));
        end
        mem_rd_valid = 1'b0;

        // Atomic pair from req0 while req1 waits; req1 address upper bits masked
        req0_cmd_valid = 1'b1; req0_cmd_data = 32'h100; req0_cmd_last = 1'b0;
        req1_cmd_valid = 1'b1; req1_cmd_data = 32'hFFE0_0200; req1_cmd_last = 1'b1;
        #1;
        check("lk_r0_rdy", 64'(req0_cmd_ready), 64'd1);
        check("lk_r1_rdy", 64'(req1_cmd_ready), 64'd0);
        tick();
        check("lk_data0", 64'(mem_rdcmd_data), 64'h100);
        req0_cmd_valid = 1'b0;
        #1;
        check("lk_r1_blocked_gap", 64'(req1_cmd_ready), 64'd0);
        tick();
        check("lk_gap_valid", 64'(mem_rdcmd_valid), 64'd0);
        req0_cmd_valid = 1'b1; req0_cmd_data = 32'h101; req0_cmd_last = 1'b1;
        #1;
        check("lk_r1_blocked", 64'(req1_cmd_ready), 64'd0);
        check("lk_r0_rdy2", 64'(req0_cmd_ready), 64'd1);
        tick();
        check("lk_data1", 64'(mem_rdcmd_data), 64'h101);
        req0_cmd_valid = 1'b0;
        #1;
        check("lk_r1_free", 64'(req1_cmd_ready), 64'd1);
        tick();
        check("lk_mask", 64'(mem_rdcmd_data), 64'h200);
        check("lk_out", 64'(outstanding), 64'd3);
        req1_cmd_valid = 1'b0;

        // Drain tags 0,0,1
        mem_rd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("lkdr_rsp1v%0d", i), 64'(rsp1_valid), (i == 2) ? 64'd1 : 64'd0);
            tick();
        end
        mem_rd_valid = 1'b0;
        check("lkdr_out", 64'(outstanding), 64'd0);

        // Issue req0, req1, req0 then return responses with a req1 stall
        req0_cmd_valid = 1'b1; req0_cmd_data = 32'hA;
        tick();
        req0_cmd_valid = 1'b0; req1_cmd_valid = 1'b1; req1_cmd_data = 32'hB;
        tick();
        req1_cmd_valid = 1'b0; req0_cmd_valid = 1'b1; req0_cmd_data = 32'hC;
        tick();
        req0_cmd_valid = 1'b0;
        check("ord_out3", 64'(outstanding), 64'd3);
        mem_rd_valid = 1'b1; mem_rd_data = DW'(64'h1111);
        #1;
        check("ord_r0v", 64'(rsp0_valid), 64'd1);
        check("ord_r0d", rsp0_data[63:0], 64'h1111);
        tick();
        mem_rd_data = DW'(64'h2222); rsp1_ready = 1'b0;
        #1;
        check("ord_r1v", 64'(rsp1_valid), 64'd1);
        check("ord_r0v_off", 64'(rsp0_valid), 64'd0);
        check("ord_stall", 64'(mem_rd_ready), 64'd0);
        tick();
        check("ord_out_stall", 64'(outstanding), 64'd2);
        rsp1_ready = 1'b1;
        #1;
        check("ord_unstall", 64'(mem_rd_ready), 64'd1);
        check("ord_r1d", rsp1_data[63:0], 64'h2222);
        tick();
        mem_rd_data = DW'(64'h3333);
        #1;
        check("ord_r0v3", 64'(rsp0_valid), 64'd1);
        tick();
        mem_rd_valid = 1'b0;
        check("ord_out0", 64'(outstanding), 64'd0);

        // Unsolicited response
        mem_rd_valid = 1'b1;
        #1;
        check("uns_rdy", 64'(mem_rd_ready), 64'd0);
        check("uns_r0v", 64'(rsp0_valid), 64'd0);
        check("uns_r1v", 64'(rsp1_valid), 64'd0);
        tick();
        mem_rd_valid = 1'b0;
        check("uns_err", 64'(err_unsolicited), 64'd1);
        tick();
        check("uns_sticky", 64'(err_unsolicited), 64'd1);

        // Fill the tag FIFO to 32 with no responses
        req0_cmd_valid = 1'b1; req0_cmd_last = 1'b1;
        for (int i = 0; i < 32; i++) begin
            req0_cmd_data = 32'h300 + 32'(i);
            #1;
            check($sformatf("fill_rdy%0d", i), 64'(req0_cmd_ready), 64'd1);
            tick();
        end
        check("fill_out", 64'(outstanding), 64'd32);
        check("fill_data", 64'(mem_rdcmd_data), 64'h31F);
        req0_cmd_data = 32'h320;
        #1;
        check("full_rdy", 64'(req0_cmd_ready), 64'd0);
        tick();
        check("full_out_hold", 64'(outstanding), 64'd32);
        mem_rd_valid = 1'b1;
        #1;
        check("full_pop_rdy", 64'(mem_rd_ready), 64'd1);
        check("full_no_bypass", 64'(req0_cmd_ready), 64'd0);
        tick();
        check("pop_out", 64'(outstanding), 64'd31);
        #1;
        check("pop_rdy_next", 64'(req0_cmd_ready), 64'd1);
        tick();
        check("pushpop_out", 64'(outstanding), 64'd31);
        check("pushpop_data", 64'(mem_rdcmd_data), 64'h320);
        mem_rd_valid = 1'b0; req0_cmd_data = 32'h321;
        tick();
        check("refill_out", 64'(outstanding), 64'd32);
        last_data = 32'h321;

        // Output register holds while memory back-pressures
        req0_cmd_valid = 1'b0; mem_rdcmd_ready = 1'b0;
        tick();
        tick();
        check("hold_valid", 64'(mem_rdcmd_valid), 64'd1);
        check("hold_data", 64'(mem_rdcmd_data), 64'(last_data));

        // Asynchronous reset mid-cycle with work in flight
        req0_cmd_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(mem_rdcmd_valid), 64'd0);
        check("arst_data", 64'(mem_rdcmd_data), 64'd0);
        check("arst_out", 64'(outstanding), 64'd0);
        check("arst_err", 64'(err_unsolicited), 64'd0);
        check("arst_rdy", 64'(req0_cmd_ready), 64'd0);
        tick();
        rst = 1'b0; mem_rdcmd_ready = 1'b1; req0_cmd_data = 32'h55;
        tick();
        check("post_rst_out", 64'(outstanding), 64'd1);
        check("post_rst_data", 64'(mem_rdcmd_data), 64'h55);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/muu_rdcmd_arbiter.md
MUU_RDCMD_ARBITER -- requirements
Module: muu_rdcmd_arbiter

Interface
REQ-001 SHALL have parameter MEMADDR_WIDTH, default 21: valid address bits in a read command.
REQ-002 SHALL have parameter DATA_WIDTH, default 512: read-response word width.
REQ-003 SHALL have parameter TAG_DEPTH, default 32 (power of 2): max outstanding reads tracked.
REQ-004 SHALL have ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
req0_cmd_data  in  32  read command from requester 0
req0_cmd_last  in  1  1 = final command of an atomic group
req0_cmd_valid  in  1  command valid
req0_cmd_ready  out  1  command accepted
req1_cmd_data / req1_cmd_last / req1_cmd_valid / req1_cmd_ready  as requester 0
mem_rdcmd_data  out  32  command to memory
mem_rdcmd_valid  out  1  registered valid
mem_rdcmd_ready  in  1  memory accepts command
mem_rd_data  in  DATA_WIDTH  read response word
mem_rd_valid  in  1  response valid
mem_rd_ready  out  1  response consumed
rsp0_data / rsp1_data  out  DATA_WIDTH  routed response
rsp0_valid / rsp1_valid  out  1  routed valid
rsp0_ready / rsp1_ready  in  1  requester accepts
outstanding  out  log2(TAG_DEPTH)+1  reads issued, response pending
err_unsolicited  out  1  sticky: response with no outstanding tag

Function
REQ-005 SHALL accept a command (req_cmd_ready=1) only when granted, tag FIFO not full, and output register empty or draining (mem_rdcmd_ready=1).
REQ-006 SHALL register accepted command to mem_rdcmd_data/valid one cycle after acceptance; bits [31:MEMADDR_WIDTH] forced 0, bits [MEMADDR_WIDTH-1:0] passed unmodified.
REQ-007 SHALL hold mem_rdcmd_valid and data stable until mem_rdcmd_ready=1.
REQ-008 SHALL push the granted requester index into the tag FIFO on each acceptance.
REQ-009 SHALL implement states ST_IDLE, ST_LOCK0, ST_LOCK1.
REQ-010 ST_IDLE: if one requester valid, grant it; if both, grant the one not served last (round-robin pointer, reset value favours req0).
REQ-011 Acceptance with cmd_last=0 SHALL move to ST_LOCKn for the accepted requester; cmd_last=1 stays/returns to ST_IDLE and flips round-robin pointer.
REQ-012 In ST_LOCKn only requester n SHALL be granted; other requester's ready=0 regardless of its valid; exit to ST_IDLE on accepted cmd_last=1.
REQ-013 Full-FIFO check SHALL use registered count (no same-cycle pop bypass); push and pop in same cycle leave outstanding unchanged.
REQ-014 Response routing combinational: head tag selects rspN; rspN_valid = mem_rd_valid & FIFO non-empty & head==N; other rsp valid=0; rspN_data = mem_rd_data.
REQ-015 mem_rd_ready = FIFO non-empty & rsp_ready of head requester; pop on mem_rd_valid & mem_rd_ready.
REQ-016 mem_rd_valid=1 with FIFO empty: mem_rd_ready=0, both rsp valid=0, err_unsolicited set, held until reset.
REQ-017 outstanding SHALL equal FIFO occupancy, range 0..TAG_DEPTH.
REQ-018 Responses SHALL return to requesters in command issue order; no reordering.

Reset
REQ-019 On rst: mem_rdcmd_valid=0, mem_rdcmd_data=0, req ready=0, FIFO emptied, outstanding=0, err_unsolicited=0, state ST_IDLE, pointer favours req0; in-flight commands and tags discarded.
REQ-020 After rst deassertion, first acceptance SHALL be possible on the first clock edge.

Verification
REQ-021 Both requesters valid, cmd_last=1, data 0x00000010/0x00000020, mem ready=1 -> issued order 0x10,0x20,0x10,...; outstanding increments 1 per cycle.
REQ-022 req0 sends pair (last=0 then last=1) while req1 valid throughout -> req1 ready=0 until req0 pair issued; mem sees req0 commands adjacent.
REQ-023 mem_rd_ready=0 on responses, 32 commands accepted -> outstanding=32, req ready=0; one response popped -> next command accepted one cycle later.
REQ-024 Issue req0,req1,req0; return 3 responses with rsp1_ready=0 during second -> mem_rd_ready=0 stalls; data routed 0,1,0 in order.
REQ-025 mem_rd_valid=1 with outstanding=0 -> err_unsolicited=1, no rsp valid; rst clears it.
REQ-026 rst asserted with mem_rdcmd_valid=1 and outstanding=5 -> all outputs/counters zero asynchronously, before next clock edge.
